mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store). It grants one access at a time, holds the memory port stable for a programmable number of cycles, and returns read data with a one-cycle ready pulse. It drives a global `stall` that freezes the pipeline until every pending request of the current pipeline step has been served. The MEM stage request is derived from `MemRead`, `MemWrite`, `ALUResult` and `WriteData`.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the single-port unified memory between the IF (fetch) and MEM (load/store) stages.
// Latency: MEM_LATENCY ACCESS cycles after the grant, then a one-cycle ready pulse. One IDLE cycle separates accesses.
// Backpressure: stall stays high until every request of the current pipeline step is served. Requesters hold their inputs meanwhile.
//
// Ports:
//   clk, reset                   - clock and synchronous active-high reset
//   if_req/if_addr               - fetch request (read only)
//   if_rdata/if_ready            - fetched word and its one-cycle completion pulse
//   mem_rd/mem_wr/mem_addr/mem_wdata - load/store request (rd+wr together acts as a write)
//   mem_rdata/mem_ready          - load data and the completion pulse (for loads and stores)
//   stall                        - freezes the PC and the pipeline registers
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - memory port
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              grant_mem;   // 1: current access belongs to MEM, 0: to IF
    logic              lat_we;
    logic              if_done;
    logic              mem_done;
    logic              mem_req;

    assign mem_req = mem_rd | mem_wr;

    // All port controls and ready pulses decode the state registers only.
    assign ram_en    = (state == ACCESS);
    assign ram_we    = ram_en & lat_we;
    assign if_ready  = (state == RESP) & ~grant_mem;
    assign mem_ready = (state == RESP) & grant_mem;

    // A requester stops stalling in the cycle its ready pulse appears,
    // so the pipeline advances on the edge that ends the RESP cycle.
    assign stall = (if_req  & ~(if_done  | if_ready)) |
                   (mem_req & ~(mem_done | mem_ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_mem <= 1'b0;
            lat_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // MEM holds the older instruction, so it wins a tie.
                    if (mem_req && !mem_done) begin
                        grant_mem <= 1'b1;
                        lat_we    <= mem_wr;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        cnt       <= CNT_LOAD;
                        state     <= ACCESS;
                    end else if (if_req && !if_done) begin
                        grant_mem <= 1'b0;
                        lat_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                        cnt       <= CNT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        // Read data is valid in the last access cycle only.
                        if (!lat_we) begin
                            if (grant_mem) begin
                                mem_rdata <= ram_rdata;
                            end else begin
                                if_rdata <= ram_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Done bits remember what was served during this stall; once the
            // pipeline advances, the inputs belong to a new step.
            if (!stall) begin
                if_done  <= 1'b0;
                mem_done <= 1'b0;
            end else if (state == RESP) begin
                if (grant_mem) begin
                    mem_done <= 1'b1;
                end else begin
                    if_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with MEM_LATENCY=2 and a behavioural RAM.
// Latency: expected ready cycles and data are queued when a request is driven and compared on the ready pulse.
// Backpressure: request inputs are held while stall is high, as a pipeline would.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        preload;
    logic [31:0] tb_mem [0:63];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } sb_t;

    sb_t mem_q[$];
    sb_t if_q[$];

    mem_port_arbiter #(
        .MEM_LATENCY(2),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input int idx);
        return (idx == 1) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(idx));
    endfunction

    // Behavioural RAM: combinational read while enabled, write on the edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= word(i);
        end else if (ram_en && ram_we) begin
            tb_mem[ram_addr[7:2]] <= ram_wdata;
        end
    end

    assign ram_rdata = ram_en ? tb_mem[ram_addr[7:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Samples the memory port and stall mid-cycle.
    task automatic probe(input string tag, input logic en_e, input logic we_e,
                         input logic [31:0] addr_e, input logic [31:0] wdata_e,
                         input logic stall_e);
        @(negedge clk);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'(en_e));
        chk({tag, "_ram_we"}, 32'(ram_we), 32'(en_e & we_e));
        chk({tag, "_stall"},  32'(stall),  32'(stall_e));
        if (en_e) begin
            chk({tag, "_ram_addr"}, ram_addr, addr_e);
            if (we_e) chk({tag, "_ram_wdata"}, ram_wdata, wdata_e);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            if (mem_q.size() == 0) begin
                chk("mem_ready_unexpected", 32'(mem_ready), 32'd0);
            end else begin
                sb_t e;
                e = mem_q.pop_front();
                chk("mem_ready_cycle", 32'(cyc), 32'(e.cyc));
                chk("mem_rdata", mem_rdata, e.data);
            end
        end
        if (if_ready === 1'b1) begin
            if (if_q.size() == 0) begin
                chk("if_ready_unexpected", 32'(if_ready), 32'd0);
            end else begin
                sb_t e;
                e = if_q.pop_front();
                chk("if_ready_cycle", 32'(cyc), 32'(e.cyc));
                chk("if_rdata", if_rdata, e.data);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fetch_exp [0:2];
        int t0;

        fetch_exp[0] = word(0);
        fetch_exp[1] = 32'hDEAD_BEEF;
        fetch_exp[2] = word(2);

        // Reset with both requests active.
        reset     = 1'b1;
        preload   = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        mem_rd    = 1'b1;
        mem_wr    = 1'b0;
        mem_addr  = 32'h4;
        mem_wdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_if_ready",  32'(if_ready),  32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_ram_en",    32'(ram_en),    32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_if_rdata",  if_rdata,       32'd0);
        chk("rst_mem_rdata", mem_rdata,      32'd0);
        chk("rst_ram_addr",  ram_addr,       32'd0);
        chk("rst_ram_wdata", ram_wdata,      32'd0);

        // MEM read of 0x4 granted right after reset release.
        if_req  = 1'b0;
        reset   = 1'b0;
        preload = 1'b0;
        t0 = cyc;
        mem_q.push_back('{cyc: t0 + 3, data: 32'h1234_5678});
        probe("rd_c0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1); next_cycle();
        probe("rd_c1", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1); next_cycle();
        probe("rd_c2", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1); next_cycle();
        probe("rd_c3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();

        // MEM write of 0xDEADBEEF to 0x4; mem_rdata keeps the last load.
        mem_rd    = 1'b0;
        mem_wr    = 1'b1;
        mem_wdata = 32'hDEAD_BEEF;
        t0 = cyc;
        mem_q.push_back('{cyc: t0 + 3, data: 32'h1234_5678});
        probe("wr_c0", 1'b0, 1'b0, 32'h0, 32'h0,         1'b1); next_cycle();
        probe("wr_c1", 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b1); next_cycle();
        probe("wr_c2", 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, 1'b1); next_cycle();
        probe("wr_c3", 1'b0, 1'b0, 32'h0, 32'h0,         1'b0); next_cycle();

        // Read back 0x4.
        mem_wr = 1'b0;
        mem_rd = 1'b1;
        t0 = cyc;
        mem_q.push_back('{cyc: t0 + 3, data: 32'hDEAD_BEEF});
        probe("rb_c0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1); next_cycle();
        probe("rb_c1", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1); next_cycle();
        probe("rb_c2", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1); next_cycle();
        probe("rb_c3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();

        // Simultaneous IF 0x40 and MEM read 0x8: MEM first, then IF.
        if_req   = 1'b1;
        if_addr  = 32'h40;
        mem_addr = 32'h8;
        t0 = cyc;
        mem_q.push_back('{cyc: t0 + 3, data: word(2)});
        if_q.push_back('{cyc: t0 + 7, data: word(16)});
        probe("both_c0", 1'b0, 1'b0, 32'h0,  32'h0, 1'b1); next_cycle();
        probe("both_c1", 1'b1, 1'b0, 32'h8,  32'h0, 1'b1); next_cycle();
        probe("both_c2", 1'b1, 1'b0, 32'h8,  32'h0, 1'b1); next_cycle();
        probe("both_c3", 1'b0, 1'b0, 32'h0,  32'h0, 1'b1); next_cycle();
        probe("both_c4", 1'b0, 1'b0, 32'h0,  32'h0, 1'b1); next_cycle();
        probe("both_c5", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1); next_cycle();
        probe("both_c6", 1'b1, 1'b0, 32'h40, 32'h0, 1'b1); next_cycle();
        probe("both_c7", 1'b0, 1'b0, 32'h0,  32'h0, 1'b0); next_cycle();

        // Reset in cycle 1 of a MEM read aborts it without a ready pulse.
        if_req = 1'b0;
        probe("abort_c0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1); next_cycle();
        reset = 1'b1;
        probe("abort_c1", 1'b1, 1'b0, 32'h8, 32'h0, 1'b1); next_cycle();
        reset  = 1'b0;
        mem_rd = 1'b0;
        probe("abort_c2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("abort_c2_mem_ready", 32'(mem_ready), 32'd0);
        next_cycle();
        probe("abort_c3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();
        probe("abort_c4", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();

        // Continuous fetches 0x0, 0x4, 0x8, one every 4 cycles.
        if_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_addr = 32'(k * 4);
            t0 = cyc;
            if_q.push_back('{cyc: t0 + 3, data: fetch_exp[k]});
            probe("fetch_c0", 1'b0, 1'b0, 32'h0,    32'h0, 1'b1); next_cycle();
            probe("fetch_c1", 1'b1, 1'b0, if_addr,  32'h0, 1'b1); next_cycle();
            probe("fetch_c2", 1'b1, 1'b0, if_addr,  32'h0, 1'b1); next_cycle();
            probe("fetch_c3", 1'b0, 1'b0, 32'h0,    32'h0, 1'b0); next_cycle();
        end
        if_req = 1'b0;

        // Quiet tail: no requests keeps stall low and the port idle.
        probe("quiet_c0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();
        probe("quiet_c1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); next_cycle();

        chk("sb_mem_left", 32'(mem_q.size()), 32'd0);
        chk("sb_if_left",  32'(if_q.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
